// File: rtl/excp_flush_ctrl_pkg.sv
// Shared types for the exception/ertn/interrupt flush sequencer.
// Holds the FSM state encoding, event-type encoding and ecode constants.
// Pure declarations; no logic, no latency, no flow control.
package excp_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EX   = 2'd1,
    EV_ERTN = 2'd2,
    EV_INT  = 2'd3
  } ev_t;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;

  // Exceptions and interrupts both write ESTAT/ERA/PRMD and kill the WB instruction.
  function automatic logic ev_commits_cause(ev_t ev);
    return (ev == EV_EX) || (ev == EV_INT);
  endfunction

endpackage

// File: rtl/excp_event_prio.sv
// Picks the winning WB event: exception > ertn > interrupt, only with a valid WB instruction.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the result is sampled.
module excp_event_prio
  import excp_flush_ctrl_pkg::*;
(
  input  logic wb_valid,
  input  logic wb_ex,
  input  logic wb_ertn,
  input  logic int_pending,
  output ev_t  ev_type,
  output logic take,
  output logic kill
);

  // Priority select; an ertn that wins is not killed since it has no rf write.
  always_comb begin
    ev_type = EV_NONE;
    if (wb_valid) begin
      if (wb_ex) begin
        ev_type = EV_EX;
      end else if (wb_ertn) begin
        ev_type = EV_ERTN;
      end else if (int_pending) begin
        ev_type = EV_INT;
      end
    end
    take = (ev_type != EV_NONE);
    kill = ev_commits_cause(ev_type);
  end

endmodule

// File: rtl/excp_flush_ctrl.sv
// Sequences flush, CSR cause commit and fetch redirect for WB exceptions, ertn and interrupts.
// Event at T: commit pulse at T+1 (FLUSH), redirect offered from T+2 (REDIR); min 3 cycles to IDLE.
// Redirect holds valid/pc stable until redirect_ready; all new events are ignored while busy.
module excp_flush_ctrl
  import excp_flush_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter logic [5:0] INT_ECODE = 6'h00
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic              wb_ex,
  input  logic [5:0]        wb_ecode,
  input  logic [8:0]        wb_esubcode,
  input  logic              wb_ertn,
  input  logic              int_pending,
  input  logic [ADDR_W-1:0] csr_eentry,
  input  logic [ADDR_W-1:0] csr_era,
  output logic              wb_kill,
  output logic              flush,
  output logic              csr_ex_commit,
  output logic [5:0]        csr_ex_ecode,
  output logic [8:0]        csr_ex_esubcode,
  output logic [ADDR_W-1:0] csr_ex_era,
  output logic              csr_ertn_commit,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              busy
);

  state_t state;
  state_t state_nxt;
  ev_t    ev_type;
  logic   ev_take;
  logic   ev_kill;
  logic   idle;
  logic   start;

  excp_event_prio u_prio (
    .wb_valid    (wb_valid),
    .wb_ex       (wb_ex),
    .wb_ertn     (wb_ertn),
    .int_pending (int_pending),
    .ev_type     (ev_type),
    .take        (ev_take),
    .kill        (ev_kill)
  );

  assign idle    = (state == IDLE);
  assign start   = idle & ev_take;
  assign busy    = ~idle;
  assign flush   = ~idle;
  assign wb_kill = (idle & ev_kill) | ~idle;

  // Next-state: one FLUSH cycle, then REDIR until IF takes the redirect.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev_take) state_nxt = FLUSH;
      FLUSH:   state_nxt = REDIR;
      REDIR:   if (redirect_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Cause/target capture at T and commit pulses that land exactly on the FLUSH cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csr_ex_commit   <= 1'b0;
      csr_ertn_commit <= 1'b0;
      csr_ex_ecode    <= '0;
      csr_ex_esubcode <= '0;
      csr_ex_era      <= '0;
      redirect_pc     <= '0;
    end else begin
      csr_ex_commit   <= start & ev_commits_cause(ev_type);
      csr_ertn_commit <= start & (ev_type == EV_ERTN);
      if (start) begin
        // CSR values are frozen here so later CSR writes cannot move the target.
        redirect_pc <= (ev_type == EV_ERTN) ? csr_era : csr_eentry;
        if (ev_commits_cause(ev_type)) begin
          csr_ex_ecode    <= (ev_type == EV_EX) ? wb_ecode : INT_ECODE;
          csr_ex_esubcode <= (ev_type == EV_EX) ? wb_esubcode : 9'd0;
          csr_ex_era      <= wb_pc;
        end
      end
    end
  end

  // Redirect offer: raised entering REDIR, dropped on the accepting handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
    end else if (state == FLUSH) begin
      redirect_valid <= 1'b1;
    end else if (redirect_valid && redirect_ready) begin
      redirect_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// Scoreboard bench: stimulus pushes expected commits/redirects, a negedge monitor pops and compares.
// Reference model is the priority rule plus fixed protocol timing (commit T+1, redirect T+2).
// Random WB junk and CSR changes are driven while busy and must have no effect.
module tb_excp_flush_ctrl;
  import excp_flush_ctrl_pkg::*;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wb_valid, wb_ex, wb_ertn, int_pending;
  logic [AW-1:0] wb_pc, csr_eentry, csr_era;
  logic [5:0]    wb_ecode;
  logic [8:0]    wb_esubcode;
  logic          wb_kill, flush, csr_ex_commit, csr_ertn_commit;
  logic [5:0]    csr_ex_ecode;
  logic [8:0]    csr_ex_esubcode;
  logic [AW-1:0] csr_ex_era, redirect_pc;
  logic          redirect_valid, redirect_ready, busy;

  excp_flush_ctrl #(.ADDR_W(AW), .INT_ECODE(6'h00)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_ertn(wb_ertn), .int_pending(int_pending),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .wb_kill(wb_kill), .flush(flush),
    .csr_ex_commit(csr_ex_commit), .csr_ex_ecode(csr_ex_ecode),
    .csr_ex_esubcode(csr_ex_esubcode), .csr_ex_era(csr_ex_era),
    .csr_ertn_commit(csr_ertn_commit),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    bit         is_ertn;
    logic [5:0] ecode;
    logic [8:0] esub;
    logic [31:0] era;
    int         cyc;
  } commit_t;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } redir_t;

  commit_t cq[$];
  redir_t  rq[$];
  commit_t mon_c;
  bit      redir_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every commit pulse and every offered redirect must match the queue heads.
  always @(negedge clk) begin
    if (resetn) begin
      if (csr_ex_commit || csr_ertn_commit) begin
        if (cq.size() == 0) begin
          chk1("unexpected_commit", 1'b1, 1'b0);
        end else begin
          mon_c = cq.pop_front();
          chkw("commit_cycle", cyc, mon_c.cyc);
          chk1("commit_ertn", csr_ertn_commit, mon_c.is_ertn);
          chk1("commit_ex", csr_ex_commit, !mon_c.is_ertn);
          chk1("commit_flush", flush, 1'b1);
          if (!mon_c.is_ertn) begin
            chkw("commit_ecode", 32'(csr_ex_ecode), 32'(mon_c.ecode));
            chkw("commit_esub", 32'(csr_ex_esubcode), 32'(mon_c.esub));
            chkw("commit_era", csr_ex_era, mon_c.era);
          end
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          chk1("unexpected_redirect", 1'b1, 1'b0);
        end else begin
          if (!redir_seen) begin
            chkw("redirect_cycle", cyc, rq[0].cyc);
            redir_seen = 1'b1;
          end
          chkw("redirect_pc", redirect_pc, rq[0].pc);
          chk1("redirect_flush", flush, 1'b1);
          if (redirect_ready) begin
            void'(rq.pop_front());
            redir_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0; int_pending = 1'b0;
    redirect_ready = 1'b0;
  endtask

  task automatic junk();
    wb_valid    = 1'($urandom_range(0, 1));
    wb_ex       = 1'($urandom_range(0, 1));
    wb_ertn     = 1'($urandom_range(0, 1));
    int_pending = 1'($urandom_range(0, 1));
    wb_ecode    = 6'($urandom);
    wb_esubcode = 9'($urandom);
    wb_pc       = $urandom;
    csr_eentry  = $urandom;
    csr_era     = $urandom;
  endtask

  // One WB cycle of stimulus, then follow the sequence with the given REDIR stall length.
  task automatic do_txn(input bit v, input bit ex, input bit ertn, input bit ip,
                        input logic [5:0] ec, input logic [8:0] esc, input logic [31:0] pc,
                        input logic [31:0] ee, input logic [31:0] era, input int delay);
    bit take;
    bit kill;
    logic [31:0] tgt;
    step();
    wb_valid = v; wb_ex = ex; wb_ertn = ertn; int_pending = ip;
    wb_ecode = ec; wb_esubcode = esc; wb_pc = pc; csr_eentry = ee; csr_era = era;
    redirect_ready = 1'($urandom_range(0, 1));
    take = 1'b0; kill = 1'b0; tgt = '0;
    if (v && ex) begin
      take = 1'b1; kill = 1'b1; tgt = ee;
      cq.push_back('{1'b0, ec, esc, pc, cyc + 1});
    end else if (v && ertn) begin
      take = 1'b1; tgt = era;
      cq.push_back('{1'b1, 6'h00, 9'h000, 32'h0, cyc + 1});
    end else if (v && ip) begin
      take = 1'b1; kill = 1'b1; tgt = ee;
      cq.push_back('{1'b0, 6'h00, 9'h000, pc, cyc + 1});
    end
    if (take) rq.push_back('{tgt, cyc + 2});
    @(negedge clk);
    chk1("kill_at_T", wb_kill, kill);
    chk1("busy_at_T", busy, 1'b0);
    if (!take) begin
      step();
      idle_inputs();
      @(negedge clk);
      chk1("no_event_busy", busy, 1'b0);
      chk1("no_event_flush", flush, 1'b0);
      return;
    end
    step();
    junk();
    redirect_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk1("flush_cyc_flush", flush, 1'b1);
    chk1("flush_cyc_kill", wb_kill, 1'b1);
    chk1("flush_cyc_rvalid", redirect_valid, 1'b0);
    for (int i = 0; i < delay; i++) begin
      step();
      junk();
      redirect_ready = 1'b0;
      @(negedge clk);
      chk1("stall_busy", busy, 1'b1);
      chk1("stall_kill", wb_kill, 1'b1);
      chk1("stall_rvalid", redirect_valid, 1'b1);
    end
    step();
    junk();
    redirect_ready = 1'b1;
    @(negedge clk);
    chk1("hs_rvalid", redirect_valid, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    chk1("post_hs_busy", busy, 1'b0);
    chk1("post_hs_rvalid", redirect_valid, 1'b0);
    chk1("post_hs_flush", flush, 1'b0);
  endtask

  task automatic chk_quiet(input string name);
    chk1({name, "_busy"}, busy, 1'b0);
    chk1({name, "_flush"}, flush, 1'b0);
    chk1({name, "_rvalid"}, redirect_valid, 1'b0);
    chk1({name, "_excommit"}, csr_ex_commit, 1'b0);
    chk1({name, "_ertncommit"}, csr_ertn_commit, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; csr_eentry = '0; csr_era = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk1("reset_kill", wb_kill, 1'b0);
    chkw("reset_rpc", redirect_pc, 32'h0);
    chkw("reset_era", csr_ex_era, 32'h0);
    chkw("reset_ecode", 32'(csr_ex_ecode), 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Syscall, ertn, interrupt-vs-ertn, interrupt on an ordinary instruction.
    do_txn(1, 1, 0, 0, 6'h0B, 9'h000, 32'h1C000100, 32'h1C008000, 32'h0, 0);
    do_txn(1, 0, 1, 0, 6'h00, 9'h000, 32'h1C000300, 32'h1C008000, 32'h1C000104, 0);
    do_txn(1, 0, 1, 1, 6'h00, 9'h000, 32'h1C000400, 32'h1C008000, 32'h1C000108, 1);
    do_txn(1, 0, 0, 1, 6'h2A, 9'h011, 32'h1C000200, 32'h1C008000, 32'h0, 2);
    // Backpressure, exception+ertn together, invalid WB with exception, idle WB instruction.
    do_txn(1, 1, 0, 0, 6'h0C, 9'h005, 32'h1C000500, 32'h1C00A000, 32'h0, 5);
    do_txn(1, 1, 1, 1, 6'h0D, 9'h1FF, 32'h1C000600, 32'h1C00B000, 32'h1C000700, 0);
    do_txn(0, 1, 1, 1, 6'h08, 9'h000, 32'h1C000800, 32'h1C00C000, 32'h1C000900, 0);
    do_txn(1, 0, 0, 0, 6'h09, 9'h000, 32'h1C000A00, 32'h1C00C000, 32'h1C000900, 0);

    // Reset during FLUSH: everything drops at once and nothing follows.
    step();
    wb_valid = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h09; wb_pc = 32'h1C000C00;
    csr_eentry = 32'h1C00D000;
    @(negedge clk);
    chk1("abort_kill_at_T", wb_kill, 1'b1);
    step();
    idle_inputs();
    #2 resetn = 1'b0;
    #1;
    chk_quiet("abort");
    repeat (2) @(negedge clk);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_quiet("post_abort");
      step();
    end

    // Pending interrupt with no valid WB instruction is held off.
    for (int i = 0; i < 10; i++) begin
      step();
      wb_valid = 1'b0; int_pending = 1'b1; wb_ex = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_quiet("idle_int");
      chk1("idle_int_kill", wb_kill, 1'b0);
    end
    do_txn(1, 0, 0, 1, 6'h3F, 9'h0AA, 32'h1C000E00, 32'h1C00E000, 32'h0, 1);

    // Randomised events.
    for (int n = 0; n < 150; n++) begin
      do_txn(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
             6'($urandom), 9'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chkw("commit_queue_drained", cq.size(), 32'd0);
    chkw("redirect_queue_drained", rq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/excp_flush_ctrl.md
Name: excp_flush_ctrl

Overview:
- Sequences pipeline recovery for exceptions, ertn and interrupts detected at the write-back stage.
- Selects the highest-priority event, holds the flush over every stage, and commits the cause to the CSR file.
- Hands the redirect PC to fetch with a valid/ready handshake.
- Sits between the WB stage, the CSR file and the IF stage.

Parameters:
- ADDR_W, 32, PC and CSR address-value width.
- INT_ECODE, 6'h00, ecode committed for a taken interrupt.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
wb_valid  in  1  WB stage holds a valid instruction this cycle
wb_pc  in  ADDR_W  PC of the WB instruction
wb_ex  in  1  WB instruction raised an exception
wb_ecode  in  6  exception ecode
wb_esubcode  in  9  exception esubcode
wb_ertn  in  1  WB instruction is ertn
int_pending  in  1  CSR file: enabled interrupt pending
csr_eentry  in  ADDR_W  CSR EENTRY read value
csr_era  in  ADDR_W  CSR ERA read value
wb_kill  out  1  suppress rf/CSR writes of the current WB instruction
flush  out  1  kill IF/ID/EX/MEM contents
csr_ex_commit  out  1  one-cycle pulse: write ESTAT/ERA/PRMD
csr_ex_ecode  out  6  committed ecode
csr_ex_esubcode  out  9  committed esubcode
csr_ex_era  out  ADDR_W  committed ERA
csr_ertn_commit  out  1  one-cycle pulse: restore PRMD to CRMD
redirect_valid  out  1  redirect PC offered to IF
redirect_pc  out  ADDR_W  new fetch PC
redirect_ready  in  1  IF accepts redirect
busy  out  1  state != IDLE

Behaviour:
- Clocking: single clock, clk. Reset is asynchronous and active-low on resetn.
- Reset state: IDLE. All registered outputs are 0: csr_ex_commit, csr_ertn_commit, csr_ex_ecode, csr_ex_esubcode, csr_ex_era, redirect_valid, redirect_pc. Consequently flush, wb_kill and busy are also 0.
- Event detection is sampled only in IDLE with wb_valid=1. Priority is wb_ex > wb_ertn > int_pending.
  - EX: capture ecode, esubcode, era=wb_pc, target=csr_eentry.
  - ERTN: capture target=csr_era.
  - INT: capture ecode=INT_ECODE, esubcode=0, era=wb_pc, target=csr_eentry.
- wb_kill is combinational: (IDLE & wb_valid & (wb_ex | int_pending) & ~wb_ertn_wins) | (state != IDLE).
  - wb_ertn_wins means ertn is the selected event.
  - An ertn itself is not killed; it has no rf write.
  - wb_ex=1 with wb_ertn=1 is resolved as EX, and the instruction is killed.
- Cycle T (event sampled in IDLE): the capture registers load at the T->T+1 edge; state moves to FLUSH.
- Cycle T+1, FLUSH:
  - flush=1, wb_kill=1.
  - csr_ex_commit=1 for EX/INT, or csr_ertn_commit=1 for ERTN, for exactly this one cycle.
  - Next state is REDIR.
- REDIR:
  - flush=1, wb_kill=1, redirect_valid=1, redirect_pc=captured target. These hold stable until redirect_ready.
  - A cycle with redirect_valid & redirect_ready completes the handshake; the next state is IDLE and redirect_valid drops.
  - Minimum event-to-IDLE is 3 cycles: T, FLUSH, REDIR with ready=1.
- While state != IDLE: all WB inputs, int_pending and new events are ignored. No event is queued.
- int_pending alone with wb_valid=0 takes no action. The interrupt waits for the next valid WB instruction.
- csr_eentry and csr_era are sampled at T only. CSR writes during FLUSH do not alter redirect_pc.
- Asynchronous reset mid-sequence (any state) returns to IDLE with all outputs 0 immediately. No pending commit pulse is emitted afterwards.
- redirect_ready asserted outside REDIR is ignored.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, FLUSH=2'd1, REDIR=2'd2); ecode constants (INT=6'h00, SYS=6'h0B, BRK=6'h0C, INE=6'h0D, ADE=6'h08, ALE=6'h09); event-type encoding (EV_EX, EV_ERTN, EV_INT).
- One combinational sub-module is natural: excp_event_prio. Inputs are wb_valid, wb_ex, wb_ertn and int_pending; it returns the event type, a take signal and the kill term.
- FSM and capture registers stay in the top.

Test Plan:
- Syscall: wb_valid=1, wb_ex=1, ecode=0x0B, wb_pc=0x1C000100, eentry=0x1C008000. Required: wb_kill=1 at T; T+1 csr_ex_commit=1, ecode=0x0B, era=0x1C000100, flush=1; T+2 redirect_valid=1, pc=0x1C008000; with ready=1, busy=0 at T+3.
- Ertn: wb_ertn=1, csr_era=0x1C000104. Required: wb_kill=0 at T; T+1 csr_ertn_commit=1, csr_ex_commit=0; redirect_pc=0x1C000104.
- Interrupt with ertn in WB (wb_valid=1, wb_ertn=1, int_pending=1): ERTN wins, no csr_ex_commit. Interrupt with an ordinary instruction at pc 0x1C000200: ecode=0x00, era=0x1C000200, wb_kill=1 at T.
- Backpressure: redirect_ready=0 for 5 cycles in REDIR. Required: redirect_valid, redirect_pc, flush held stable; a new wb_ex during REDIR is ignored; exit one cycle after ready=1.
- Reset abort: resetn=0 during FLUSH. Required: csr_ex_commit, flush, busy drop immediately; after release no redirect is issued.
- Idle interrupt: int_pending=1, wb_valid=0 for 10 cycles. Required: no output activity; taken on the first wb_valid=1 cycle.
